// File: rtl/voice_allocator.sv
// Four-voice note allocator for AD envelope generators.
// Note-ons retrigger a voice that already holds the note. Otherwise they take
// the lowest free voice, or steal the least recently assigned voice. Retriggers
// and steals force a gate-low gap so the envelope sees a fresh rising edge.
//
// state  | meaning
// IDLE   | ready for a key event
// LOOKUP | latched event is matched against the voices and applied
// GAP    | selected voice held gate-low before re-rising
module voice_allocator #(
  parameter int GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ev_valid,
  output logic        ev_ready,
  input  logic        ev_on,
  input  logic [6:0]  ev_note,
  output logic [3:0]  voice_gate,
  output logic [27:0] voice_note,
  output logic        steal_pulse,
  output logic [2:0]  active_count
);

  typedef enum logic [1:0] {IDLE, LOOKUP, GAP} state_t;

  // Gap timer is a down-counter that exits on terminal count zero.
  localparam logic [3:0] GAP_LOAD = 4'(GAP_CYCLES - 1);

  state_t     state;
  logic       on_q;
  logic [6:0] note_q;
  logic [3:0] held;
  logic [3:0] gate;
  logic [6:0] note_r [4];
  logic [1:0] rank [4];
  logic [3:0] gap_cnt;
  logic [1:0] gap_idx;

  logic       hit;
  logic [1:0] hit_idx;
  logic       free;
  logic [1:0] free_idx;
  logic [1:0] lru_idx;
  logic [1:0] sel;

  // Voice lookup: matching held voice, lowest free voice, and rank-3 voice.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = 2'd0;
    free     = 1'b0;
    free_idx = 2'd0;
    lru_idx  = 2'd0;
    // Descending scan so the lowest index wins.
    for (int i = 3; i >= 0; i--) begin
      if (held[i] && note_r[i] == note_q) begin
        hit     = 1'b1;
        hit_idx = 2'(i);
      end
      if (!held[i]) begin
        free     = 1'b1;
        free_idx = 2'(i);
      end
      if (rank[i] == 2'd3) lru_idx = 2'(i);
    end
    if (hit)       sel = hit_idx;
    else if (free) sel = free_idx;
    else           sel = lru_idx;
  end

  // Output packing and held-voice popcount.
  always_comb begin
    voice_note   = '0;
    active_count = '0;
    for (int i = 0; i < 4; i++) begin
      voice_note[7*i +: 7] = note_r[i];
      active_count         = active_count + 3'(held[i]);
    end
  end

  assign voice_gate = gate;
  assign ev_ready   = (state == IDLE) && !rst;

  // Allocator state machine with registered voice outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      on_q        <= 1'b0;
      note_q      <= '0;
      held        <= '0;
      gate        <= '0;
      steal_pulse <= 1'b0;
      gap_cnt     <= '0;
      gap_idx     <= '0;
      for (int i = 0; i < 4; i++) begin
        note_r[i] <= '0;
        rank[i]   <= 2'(i);
      end
    end else begin
      steal_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (ev_valid) begin
            on_q   <= ev_on;
            note_q <= ev_note;
            state  <= LOOKUP;
          end
        end
        LOOKUP: begin
          state <= IDLE;
          if (on_q) begin
            note_r[sel] <= note_q;
            held[sel]   <= 1'b1;
            // Move the chosen voice to rank 0 and age voices that were newer.
            for (int i = 0; i < 4; i++) begin
              if (2'(i) == sel)           rank[i] <= 2'd0;
              else if (rank[i] < rank[sel]) rank[i] <= rank[i] + 2'd1;
            end
            if (hit || !free) begin
              gate[sel]   <= 1'b0;
              gap_cnt     <= GAP_LOAD;
              gap_idx     <= sel;
              steal_pulse <= !hit;
              state       <= GAP;
            end else begin
              gate[sel] <= 1'b1;
            end
          end else if (hit) begin
            gate[hit_idx] <= 1'b0;
            held[hit_idx] <= 1'b0;
          end
        end
        GAP: begin
          if (gap_cnt == 4'd0) begin
            gate[gap_idx] <= 1'b1;
            state         <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: default-gap instance for allocation,
// stealing, note-off and reset behaviour; GAP_CYCLES=3 instance for retrigger.
module tb_voice_allocator;

  logic        clk;
  logic        rst, ev_valid, ev_on, ev_ready, steal_pulse;
  logic [6:0]  ev_note;
  logic [3:0]  voice_gate;
  logic [27:0] voice_note;
  logic [2:0]  active_count;

  logic        b_rst, b_valid, b_on, b_ready, b_steal;
  logic [6:0]  b_note;
  logic [3:0]  b_gate;
  logic [27:0] b_vnote;
  logic [2:0]  b_count;

  int checks = 0;
  int errors = 0;

  voice_allocator u_dut (
    .clk(clk), .rst(rst), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .voice_gate(voice_gate),
    .voice_note(voice_note), .steal_pulse(steal_pulse), .active_count(active_count)
  );

  voice_allocator #(.GAP_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(b_rst), .ev_valid(b_valid), .ev_ready(b_ready),
    .ev_on(b_on), .ev_note(b_note), .voice_gate(b_gate),
    .voice_note(b_vnote), .steal_pulse(b_steal), .active_count(b_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present one event to u_dut; returns two cycles after acceptance.
  task automatic send(input logic on, input logic [6:0] n);
    int w;
    w = 0;
    while (!ev_ready && w < 20) begin
      step();
      w++;
    end
    chk("ready_before_send", 32'(ev_ready), 32'd1);
    ev_on    = on;
    ev_note  = n;
    ev_valid = 1'b1;
    step();
    ev_valid = 1'b0;
    step();
  endtask

  logic [6:0] notes [4];
  int acc_cyc [4];
  int k;

  initial begin
    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_on = 1'b0; b_note = '0;
    step();
    step();
    chk("reset_ready_low", 32'(ev_ready), 32'd0);
    chk("reset_gate", 32'(voice_gate), 32'd0);
    chk("reset_count", 32'(active_count), 32'd0);
    chk("reset_notes", 32'(voice_note), 32'd0);
    chk("reset_steal", 32'(steal_pulse), 32'd0);
    rst = 1'b0;
    b_rst = 1'b0;
    #1;
    chk("ready_after_reset", 32'(ev_ready), 32'd1);

    // First note lands on voice 0 two cycles after acceptance.
    send(1'b1, 7'd60);
    chk("on60_gate", 32'(voice_gate), 32'b0001);
    chk("on60_note", 32'(voice_note[6:0]), 32'd60);
    chk("on60_count", 32'(active_count), 32'd1);

    send(1'b1, 7'd62);
    send(1'b1, 7'd64);
    send(1'b1, 7'd67);
    chk("fill_gate", 32'(voice_gate), 32'b1111);
    chk("fill_count", 32'(active_count), 32'd4);
    chk("fill_notes", 32'(voice_note), 32'({7'd67, 7'd64, 7'd62, 7'd60}));

    // Fifth note steals voice 0 (oldest); gate low for one cycle.
    send(1'b1, 7'd69);
    chk("steal_gate_low", 32'(voice_gate), 32'b1110);
    chk("steal_pulse_hi", 32'(steal_pulse), 32'd1);
    chk("steal_note", 32'(voice_note[6:0]), 32'd69);
    chk("steal_ready_low", 32'(ev_ready), 32'd0);
    step();
    chk("steal_gate_high", 32'(voice_gate), 32'b1111);
    chk("steal_pulse_lo", 32'(steal_pulse), 32'd0);
    chk("steal_count", 32'(active_count), 32'd4);

    // Note-off of a held note; then note-off of an unheld note.
    send(1'b0, 7'd62);
    chk("off62_gate", 32'(voice_gate), 32'b1101);
    chk("off62_note_kept", 32'(voice_note[13:7]), 32'd62);
    chk("off62_count", 32'(active_count), 32'd3);
    send(1'b0, 7'd100);
    chk("off100_gate", 32'(voice_gate), 32'b1101);
    chk("off100_notes", 32'(voice_note), 32'({7'd67, 7'd64, 7'd62, 7'd69}));
    chk("off100_count", 32'(active_count), 32'd3);
    chk("off100_steal", 32'(steal_pulse), 32'd0);

    // Refill voice 1, then steal again: ranks are v0=1 v1=0 v2=3 v3=2 so v2 goes.
    send(1'b1, 7'd50);
    chk("refill_gate", 32'(voice_gate), 32'b1111);
    chk("refill_note", 32'(voice_note[13:7]), 32'd50);
    send(1'b1, 7'd51);
    chk("steal2_gate_low", 32'(voice_gate), 32'b1011);
    chk("steal2_note", 32'(voice_note[20:14]), 32'd51);
    chk("steal2_pulse", 32'(steal_pulse), 32'd1);

    // Reset lands in the middle of the gap.
    rst = 1'b1;
    #1;
    chk("rst_ready_low", 32'(ev_ready), 32'd0);
    step();
    chk("gap_rst_gate", 32'(voice_gate), 32'd0);
    chk("gap_rst_count", 32'(active_count), 32'd0);
    chk("gap_rst_steal", 32'(steal_pulse), 32'd0);
    chk("gap_rst_notes", 32'(voice_note), 32'd0);
    rst = 1'b0;
    #1;
    chk("gap_rst_ready", 32'(ev_ready), 32'd1);

    // ev_valid held high across four distinct note-ons.
    notes[0] = 7'd10; notes[1] = 7'd11; notes[2] = 7'd12; notes[3] = 7'd13;
    k = 0;
    ev_on    = 1'b1;
    ev_note  = notes[0];
    ev_valid = 1'b1;
    for (int c = 0; c < 40 && k < 4; c++) begin
      if (ev_ready) begin
        acc_cyc[k] = c;
        k++;
        step();
        if (k < 4) ev_note = notes[k];
        else       ev_valid = 1'b0;
      end else begin
        step();
      end
    end
    chk("stream_accepts", 32'(k), 32'd4);
    for (int i = 0; i < 3; i++)
      chk("stream_spacing", 32'(acc_cyc[i+1] - acc_cyc[i]), 32'd2);
    step();
    chk("stream_notes", 32'(voice_note), 32'({7'd13, 7'd12, 7'd11, 7'd10}));
    chk("stream_gate", 32'(voice_gate), 32'b1111);
    chk("stream_count", 32'(active_count), 32'd4);

    // Restored ranks mean voice 0 is the oldest and gets stolen.
    send(1'b1, 7'd14);
    chk("post_rst_steal_note", 32'(voice_note[6:0]), 32'd14);
    chk("post_rst_steal_gate", 32'(voice_gate), 32'b1110);
    chk("post_rst_steal_pulse", 32'(steal_pulse), 32'd1);
    step();
    chk("post_rst_regate", 32'(voice_gate), 32'b1111);

    // Retrigger on the GAP_CYCLES=3 instance.
    b_on = 1'b1; b_note = 7'd60; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    chk("b_on60_gate", 32'(b_gate), 32'b0001);
    chk("b_on60_count", 32'(b_count), 32'd1);
    chk("b_ready", 32'(b_ready), 32'd1);
    b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("b_retrig_gate_low", 32'(b_gate), 32'b0000);
      chk("b_retrig_no_steal", 32'(b_steal), 32'd0);
      chk("b_retrig_count", 32'(b_count), 32'd1);
      chk("b_retrig_busy", 32'(b_ready), 32'd0);
      step();
    end
    chk("b_retrig_gate_high", 32'(b_gate), 32'b0001);
    chk("b_retrig_steal_end", 32'(b_steal), 32'd0);
    chk("b_retrig_note", 32'(b_vnote[6:0]), 32'd60);
    chk("b_ready_after_gap", 32'(b_ready), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
